// File: rtl/count_seq_checker.sv
// count_seq_checker: receive-side monitor that tracks a 0..TERMINAL trigger counter
// with a reference model, flagging divergences and counting clean runs.
module count_seq_checker #(
   parameter int WIDTH     = 4,
   parameter int TERMINAL  = 10,
   parameter int ERR_CNT_W = 8,
   parameter int RUN_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 trigger,
   input  logic [WIDTH-1:0]     cnt_in,
   input  logic                 clr,
   output logic                 busy,
   output logic                 run_done,
   output logic                 mismatch,
   output logic                 range_err,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [RUN_CNT_W-1:0] run_cnt
);
   localparam logic [WIDTH-1:0] L_TERM = WIDTH'(TERMINAL);
   logic [WIDTH-1:0] r_exp;
   logic             r_clean;
   logic             w_mis;
   logic             w_rng;
   logic             w_done;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_next;
   always_comb begin
      w_mis  = cnt_in != r_exp;
      w_rng  = cnt_in > L_TERM;
      // on a mismatch, follow the observed value so one glitch gives one error
      w_base = !w_mis ? r_exp : w_rng ? '0 : cnt_in;
      w_next = (w_base == '0) ? WIDTH'(trigger) : (w_base == L_TERM) ? '0 : w_base + WIDTH'(1);
      w_done = !w_mis && r_exp == L_TERM && r_clean;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp      <= '0;
         r_clean    <= 1'b0;
         busy       <= 1'b0;
         run_done   <= 1'b0;
         mismatch   <= 1'b0;
         range_err  <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         run_cnt    <= '0;
      end else begin
         r_exp     <= w_next;
         busy      <= w_next != '0;
         run_done  <= w_done;
         mismatch  <= w_mis;
         range_err <= w_rng;
         r_clean   <= w_mis ? 1'b0 : (r_exp == '0 && trigger) ? 1'b1 : r_clean;
         if (clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            run_cnt    <= '0;
         end else begin
            if (w_mis) err_sticky <= 1'b1;
            if (w_mis && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
            if (w_done) run_cnt <= run_cnt + RUN_CNT_W'(1);
         end
      end
   end
endmodule
